led_instr_sequencer: RTL and testbench
======================================

# led_instr_sequencer

Issuing end of the LED controller's 32-bit instruction bus. Host logic pushes instruction words into an internal FIFO. The sequencer presents each word to the LED controller for exactly one clock cycle, then drives NOP. It watches the controller's `state` output and issues the next word only after the controller has returned to READY. This guarantees that a held instruction is never re-executed and that no word is lost while the controller is busy.

## Interface
Parameters:
- `DEPTH`, 8, FIFO depth in words; must be a power of 2, minimum 2.
- `ACK_WINDOW`, 2, cycles after issue to wait for the controller to leave READY before the word is treated as ignored; minimum 1.
- `READY_STATE`, 0, controller state encoding for READY.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `push`  in  1  enqueue request.
- `push_data`  in  32  word to enqueue: op_code [31:24], index [23:16], operand [15:0].
- `full`  out  1  FIFO occupancy == DEPTH.
- `empty`  out  1  FIFO occupancy == 0.
- `overflow`  out  1  sticky; set when a push is dropped.
- `instruction`  out  32  to controller `instruction`; 0 (NOP) except during ISSUE.
- `ctrl_state`  in  4  from controller `state`.
- `busy`  out  1  FSM not in IDLE.
- `done`  out  1  one-cycle pulse when an issued word completes.
- `ignored`  out  1  qualifies `done`; the controller never left READY for this word.
- `issue_count`  out  16  words issued since reset; wraps 0xFFFF→0.

## Operation
- Reset (`rst_n`=0 at a rising edge) sets the following:
  - FIFO emptied: `empty`=1, `full`=0.
  - `overflow`=0, `instruction`=0, `busy`=0, `done`=0, `ignored`=0, `issue_count`=0.
  - FSM enters IDLE.
  - Reset mid-operation abandons the current word and discards queued words.
- FIFO behaviour:
  - Push is accepted when `full`=0, evaluated on the registered `full`.
  - Push while `full`=1 is dropped and sets `overflow`, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle with 0 < occupancy < DEPTH leaves occupancy unchanged.
  - Push into an empty FIFO is visible to the FSM in the next cycle. There is no fall-through.
  - Words are issued in push order. Read and write pointers wrap modulo DEPTH.
  - Words with op_code 0 are accepted and issued like any other word.
- FSM states:
  - IDLE: when FIFO is non-empty and `ctrl_state`==READY_STATE, pop the head, load it into `instruction`, increment `issue_count`, and go to ISSUE. Otherwise hold with `instruction`=0.
  - ISSUE (exactly 1 cycle): `instruction` holds the word. At the next edge, set `instruction`←0, clear the window counter, and go to WAIT_ACK.
  - WAIT_ACK: if `ctrl_state`≠READY_STATE, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches ACK_WINDOW−1, pulse `done` with `ignored`=1 and go to IDLE.
  - WAIT_DONE: when `ctrl_state`==READY_STATE, pulse `done` with `ignored`=0 and go to IDLE. There is no timeout; a stuck controller keeps `busy`=1.
- If `ctrl_state`≠READY_STATE while in IDLE (controller busy from elsewhere), issue is withheld.

## Timing
- All outputs are registered.
- `done` and `ignored` are high for exactly one cycle, in the cycle the FSM is back in IDLE.
- Issue latency: a word at the FIFO head with the controller ready appears on `instruction` 1 cycle later.
- Issue cycle as seen by the controller:
  - Cycle T: the controller sees `instruction`=word.
  - Cycle T+1: the controller sees `instruction`=0 and `state`≠READY for acted-upon opcodes. WAIT_ACK therefore observes busy in its first cycle.
- Ignored word: `done` is asserted ACK_WINDOW+1 cycles after ISSUE ends.
- Acted-upon word: `done` is asserted 1 cycle after `ctrl_state` returns to READY_STATE.
- Minimum spacing between consecutive issues: ISSUE + WAIT_ACK(≥1) + IDLE is 3 cycles for an ignored word.
- `instruction` is never non-zero for two consecutive cycles.

## Test plan
- Reset:
  - Stimulus: hold `rst_n`=0 for 2 cycles with `push`=1.
  - Required: all outputs at their reset values, `empty`=1, and no word enqueued after release.
- Single SEND_LATCH:
  - Stimulus: push 0x04010000. The controller model goes to state 1 the cycle after it sees the word and returns to 0 after 4 cycles.
  - Required: `instruction`=0x04010000 for exactly 1 cycle; `done`=1 with `ignored`=0 one cycle after state returns to 0; `issue_count`=1.
- Ignored opcode:
  - Stimulus: push 0x01000000 with the controller staying at 0.
  - Required: `done`=1 with `ignored`=1 exactly 3 cycles after the ISSUE cycle (ACK_WINDOW=2).
- Overflow:
  - Stimulus: with the controller held busy, push 8 words, then a 9th.
  - Required: after the 8th push `full`=1; the 9th word is dropped and `overflow`=1.
  - Then release the controller. Required: exactly 8 words are issued in order and `empty`=1 at the end.
- Back-to-back ordering:
  - Stimulus: push 0x04000000, 0x04010000, 0x04020000 in consecutive cycles.
  - Required: issued in order, each only after `ctrl_state` returns to 0; 3 `done` pulses.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 during WAIT_DONE with 2 words queued.
  - Required: the next cycle has `busy`=0, `empty`=1, `instruction`=0, and no `done` pulse.

Source files
------------

// File: rtl/led_instr_sequencer_if.sv
// Instruction-bus bundle between host/controller logic and led_instr_sequencer.
// master = host and LED controller side, slave = the sequencer.
interface led_instr_sequencer_if;
  logic        push;
  logic [31:0] push_data;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [31:0] instruction;
  logic [3:0]  ctrl_state;
  logic        busy;
  logic        done;
  logic        ignored;
  logic [15:0] issue_count;

  modport master (
    output push, push_data, ctrl_state,
    input  full, empty, overflow, instruction, busy, done, ignored, issue_count
  );

  modport slave (
    input  push, push_data, ctrl_state,
    output full, empty, overflow, instruction, busy, done, ignored, issue_count
  );
endinterface

// File: rtl/led_instr_sequencer.sv
// Queues host instruction words and issues each one to the LED controller for a
// single cycle, waiting for the controller to return to READY before the next.
module led_instr_sequencer #(
  parameter int DEPTH       = 8,
  parameter int ACK_WINDOW  = 2,
  parameter int READY_STATE = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  led_instr_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ACK_WINDOW > 1) ? $clog2(ACK_WINDOW) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] WIN_LAST   = CW'(ACK_WINDOW - 1);
  localparam logic [3:0]    READY      = 4'(READY_STATE);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state, state_n;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic          full, empty, overflow;
  logic [31:0]   instruction, instruction_n;
  logic [CW-1:0] win_cnt, win_cnt_n;
  logic          busy, done, done_n, ignored, ignored_n;
  logic [15:0]   issue_count;
  logic          push_ok, pop, ctrl_ready;

  assign ctrl_ready = (bus.ctrl_state == READY);
  // A push is judged against the registered full flag, so a same-cycle pop never rescues it.
  assign push_ok    = bus.push && !full;

  always_comb begin
    state_n       = state;
    instruction_n = '0;
    win_cnt_n     = win_cnt;
    done_n        = 1'b0;
    ignored_n     = 1'b0;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && ctrl_ready) begin
          pop           = 1'b1;
          instruction_n = mem[rd_ptr];
          state_n       = ISSUE;
        end
      end
      ISSUE: begin
        win_cnt_n = '0;
        state_n   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!ctrl_ready) begin
          state_n = WAIT_DONE;
        end else if (win_cnt == WIN_LAST) begin
          done_n    = 1'b1;
          ignored_n = 1'b1;
          state_n   = IDLE;
        end else begin
          win_cnt_n = win_cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (ctrl_ready) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    count_n = count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      overflow    <= 1'b0;
      instruction <= '0;
      win_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ignored     <= 1'b0;
      issue_count <= '0;
    end else begin
      state       <= state_n;
      instruction <= instruction_n;
      win_cnt     <= win_cnt_n;
      done        <= done_n;
      ignored     <= ignored_n;
      busy        <= (state_n != IDLE);
      count       <= count_n;
      full        <= (count_n == FULL_COUNT);
      empty       <= (count_n == '0);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        issue_count <= issue_count + 16'd1;
      end
      if (bus.push && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem[wr_ptr] <= bus.push_data;
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.overflow    = overflow;
  assign bus.instruction = instruction;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.ignored     = ignored;
  assign bus.issue_count = issue_count;
endmodule

// File: tb/tb_led_instr_sequencer.sv
// Bench for led_instr_sequencer: directed scenarios plus random traffic, checked
// every cycle against a timeline model of the issue/acknowledge rules.
module tb_led_instr_sequencer;
  localparam int         DEPTH      = 8;
  localparam int         ACK_WINDOW = 2;
  localparam logic [3:0] READY      = 4'd0;

  logic clk = 1'b0;
  logic rst_n;

  led_instr_sequencer_if bus ();

  led_instr_sequencer #(
    .DEPTH      (DEPTH),
    .ACK_WINDOW (ACK_WINDOW),
    .READY_STATE(0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Controller stand-in: words with op_code bit 2 set keep it non-READY for ctrl_len cycles.
  int ctrl_left = 0;
  int ctrl_len  = 4;
  bit ctrl_hold = 1'b0;

  logic [31:0] model_q[$];
  bit          out_active, out_acted;
  int          out_t;
  bit          exp_done, exp_ign, exp_ovf;
  logic [31:0] exp_instr;
  logic [15:0] exp_count;
  logic        rec_push, rec_rst;
  logic [31:0] rec_data;
  logic [3:0]  rec_ctrl;
  int          dut_done_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    out_active = 1'b0;
    out_acted  = 1'b0;
    out_t      = 0;
    exp_done   = 1'b0;
    exp_ign    = 1'b0;
    exp_ovf    = 1'b0;
    exp_instr  = '0;
    exp_count  = '0;
  endtask

  // Advances the expected view across one clock edge, using the inputs of the cycle just ended.
  task automatic model_step();
    int k     = cyc - 1;
    int qsize = model_q.size();
    bit issue_now;
    if (rec_rst !== 1'b1) begin
      model_reset();
    end else begin
      issue_now = !out_active && (qsize > 0) && (rec_ctrl == READY);
      exp_done  = 1'b0;
      exp_ign   = 1'b0;
      if (out_active && k >= out_t + 1) begin
        if (!out_acted) begin
          if (rec_ctrl != READY) out_acted = 1'b1;
          else if (k == out_t + ACK_WINDOW) begin
            exp_done = 1'b1;
            exp_ign  = 1'b1;
          end
        end else if (rec_ctrl == READY) begin
          exp_done = 1'b1;
        end
      end
      if (exp_done) out_active = 1'b0;
      exp_instr = '0;
      if (issue_now) begin
        exp_instr  = model_q.pop_front();
        out_active = 1'b1;
        out_acted  = 1'b0;
        out_t      = cyc;
        exp_count  = exp_count + 16'd1;
      end
      if (rec_push === 1'b1) begin
        if (qsize < DEPTH) model_q.push_back(rec_data);
        else exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic tick();
    if (ctrl_left > 0) begin
      bus.ctrl_state = 4'd1;
      ctrl_left--;
    end else begin
      bus.ctrl_state = ctrl_hold ? 4'd1 : READY;
    end
    if (bus.instruction !== 32'h0 && bus.instruction[26] === 1'b1) ctrl_left = ctrl_len;
    rec_push = bus.push;
    rec_data = bus.push_data;
    rec_rst  = rst_n;
    rec_ctrl = bus.ctrl_state;
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    if (bus.done === 1'b1) dut_done_seen++;
    check("instruction", bus.instruction, exp_instr);
    check("done", 32'(bus.done), 32'(exp_done));
    check("ignored", 32'(bus.ignored), 32'(exp_ign));
    check("busy", 32'(bus.busy), 32'(out_active));
    check("full", 32'(bus.full), 32'(model_q.size() == DEPTH));
    check("empty", 32'(bus.empty), 32'(model_q.size() == 0));
    check("overflow", 32'(bus.overflow), 32'(exp_ovf));
    check("issue_count", 32'(bus.issue_count), 32'(exp_count));
  endtask

  task automatic push_word(input logic [31:0] word);
    bus.push      = 1'b1;
    bus.push_data = word;
    tick();
    bus.push = 1'b0;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int i = 0;
    while ((out_active || model_q.size() > 0 || ctrl_left > 0) && i < max_cycles) begin
      tick();
      i++;
    end
    checks++;
    assert (!(out_active || model_q.size() > 0))
    else begin
      errors++;
      $error("[TB] FAIL drain_timeout: observed=busy after %0d cycles expected=idle", i);
    end
    tick();
    tick();
  endtask

  initial begin
    int          done_before;
    int          op;
    logic [31:0] word;

    model_reset();
    rst_n         = 1'b0;
    bus.push      = 1'b1;
    bus.push_data = 32'hDEAD_BEEF;
    bus.ctrl_state = READY;

    $display("[TB] reset with push held high");
    tick();
    tick();
    rst_n    = 1'b1;
    bus.push = 1'b0;
    repeat (3) tick();
    check("reset_empty", 32'(bus.empty), 32'd1);
    check("reset_count", 32'(bus.issue_count), 32'd0);

    $display("[TB] single SEND_LATCH");
    ctrl_len = 4;
    push_word(32'h0401_0000);
    run_until_idle(50);
    check("latch_count", 32'(bus.issue_count), 32'd1);

    $display("[TB] ignored opcode");
    push_word(32'h0100_0000);
    run_until_idle(50);
    check("ignored_count", 32'(bus.issue_count), 32'd2);

    $display("[TB] overflow with controller held busy");
    ctrl_hold = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) push_word(32'h0500_0000 + 32'(i));
    check("ovf_full", 32'(bus.full), 32'd1);
    check("ovf_clear_before", 32'(bus.overflow), 32'd0);
    push_word(32'h0500_0099);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    repeat (3) tick();
    ctrl_hold = 1'b0;
    run_until_idle(300);
    check("ovf_drained_empty", 32'(bus.empty), 32'd1);
    check("ovf_count", 32'(bus.issue_count), 32'd10);

    $display("[TB] back-to-back ordering");
    done_before = dut_done_seen;
    push_word(32'h0400_0000);
    push_word(32'h0401_0000);
    push_word(32'h0402_0000);
    run_until_idle(100);
    check("b2b_done_pulses", 32'(dut_done_seen - done_before), 32'd3);

    $display("[TB] reset during WAIT_DONE");
    ctrl_len = 20;
    push_word(32'h0403_0000);
    push_word(32'h0404_0000);
    push_word(32'h0405_0000);
    for (int i = 0; i < 20 && !(out_active && out_acted); i++) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_empty", 32'(bus.empty), 32'd1);
    check("midrst_instr", bus.instruction, 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    rst_n     = 1'b1;
    ctrl_left = 0;
    repeat (4) tick();
    check("midrst_count", 32'(bus.issue_count), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      ctrl_len = int'($urandom_range(1, 5));
      if ($urandom_range(0, 15) == 0) ctrl_hold = ~ctrl_hold;
      bus.push = ($urandom_range(0, 2) == 0);
      op       = int'($urandom_range(0, 7));
      word     = {8'(op), 24'($urandom)};
      if (word == 32'h0) word = 32'h1;
      bus.push_data = word;
      tick();
    end
    bus.push  = 1'b0;
    ctrl_hold = 1'b0;
    run_until_idle(400);
    check("final_empty", 32'(bus.empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
